// File: rtl/bubble_sort_pkg.sv
// Shared types and constants for the bubble-sort sequencing stage.
package bubble_sort_pkg;

    // Memory word width.
    localparam int W = 16;

    // swap_count holds at this value instead of wrapping.
    localparam logic [W-1:0] SWAP_SAT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CMP,
        WR_A,
        WR_B,
        DONE
    } sort_state_t;

endpackage

// File: rtl/bubble_sort_ctrl_register16bit.sv
// 16-bit operand register with enable and load qualifiers, async active-high reset.
module register16bit
    import bubble_sort_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d on a rising edge when both qualifiers are high.
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en && load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencer: walks an external synchronous word memory, compares
// adjacent words and writes them back swapped when out of order.
module bubble_sort_ctrl
    import bubble_sort_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [W-1:0]  mem_rd_data,
    output logic [W-1:0]  mem_wr_data,
    output logic          mem_we,
    output logic [W-1:0]  swap_count
);

    // Last legal value of pass, and the starting bound for i.
    localparam logic [AW-1:0] LAST = AW'(N - 2);

    sort_state_t   state;
    logic [AW-1:0] pass;
    logic [AW-1:0] idx;
    logic          swapped_flag;
    logic [W-1:0]  reg_a;
    logic [W-1:0]  reg_b;
    logic          step_more;
    logic          last_pass;

    // More pairs remain in the current pass; pass never exceeds LAST so no underflow.
    assign step_more = idx < (LAST - pass);
    assign last_pass = pass == LAST;

    // reg_a captures word i as it arrives during RD_B.
    register16bit u_reg_a (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .load (state == RD_B),
        .d    (mem_rd_data),
        .q    (reg_a)
    );

    // reg_b captures word i+1 as it arrives during CMP.
    register16bit u_reg_b (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .load (state == CMP),
        .d    (mem_rd_data),
        .q    (reg_b)
    );

    // Sort FSM with pass/index counters and saturating swap counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pass         <= '0;
            idx          <= '0;
            swapped_flag <= 1'b0;
            swap_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pass         <= '0;
                        idx          <= '0;
                        swapped_flag <= 1'b0;
                        swap_count   <= '0;
                        state        <= RD_A;
                    end
                end
                RD_A: state <= RD_B;
                RD_B: state <= CMP;
                CMP: begin
                    // Strict unsigned compare keeps equal words in place (stable sort).
                    if (reg_a > mem_rd_data) begin
                        state <= WR_A;
                    end else if (step_more) begin
                        idx   <= idx + AW'(1);
                        state <= RD_A;
                    end else if (!swapped_flag || last_pass) begin
                        state <= DONE;
                    end else begin
                        pass         <= pass + AW'(1);
                        idx          <= '0;
                        swapped_flag <= 1'b0;
                        state        <= RD_A;
                    end
                end
                WR_A: state <= WR_B;
                WR_B: begin
                    if (swap_count != SWAP_SAT) begin
                        swap_count <= swap_count + 16'd1;
                    end
                    // This step swapped, so only the last pass can end the sort here.
                    swapped_flag <= 1'b1;
                    if (step_more) begin
                        idx   <= idx + AW'(1);
                        state <= RD_A;
                    end else if (last_pass) begin
                        state <= DONE;
                    end else begin
                        pass         <= pass + AW'(1);
                        idx          <= '0;
                        swapped_flag <= 1'b0;
                        state        <= RD_A;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port and handshake decode from registered state and counters only.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_we      = 1'b0;
        case (state)
            RD_A: mem_addr = idx;
            RD_B: mem_addr = idx + AW'(1);
            CMP:  mem_addr = idx + AW'(1);
            WR_A: begin
                mem_addr    = idx;
                mem_wr_data = reg_b;
                mem_we      = 1'b1;
            end
            WR_B: begin
                mem_addr    = idx + AW'(1);
                mem_wr_data = reg_a;
                mem_we      = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = state != IDLE;
    assign done = state == DONE;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Self-checking bench for bubble_sort_ctrl: N=8 and N=2 builds, each with a
// synchronous memory model; expected results go through a scoreboard queue.
module tb_bubble_sort_ctrl;
    import bubble_sort_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N=8 instance
    logic        start8, busy8, done8, we8;
    logic [2:0]  addr8;
    logic [15:0] rd8, wd8, sc8;
    logic [15:0] mem8 [8];
    logic [15:0] init8 [8];
    logic        do_load8;
    int          we_cnt8 = 0;

    // N=2 instance
    logic        start2, busy2, done2, we2;
    logic [0:0]  addr2;
    logic [15:0] rd2, wd2, sc2;
    logic [15:0] mem2 [2];
    logic [15:0] init2 [2];
    logic        do_load2;

    bubble_sort_ctrl #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
        .mem_addr(addr8), .mem_rd_data(rd8), .mem_wr_data(wd8), .mem_we(we8),
        .swap_count(sc8)
    );

    bubble_sort_ctrl #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .mem_addr(addr2), .mem_rd_data(rd2), .mem_wr_data(wd2), .mem_we(we2),
        .swap_count(sc2)
    );

    // Synchronous memories with a bench-side bulk load port.
    always @(posedge clk) begin
        if (do_load8) mem8 <= init8;
        else if (we8) mem8[addr8] <= wd8;
        rd8 <= mem8[addr8];
        if (we8) we_cnt8 <= we_cnt8 + 1;
    end

    always @(posedge clk) begin
        if (do_load2) mem2 <= init2;
        else if (we2) mem2[addr2] <= wd2;
        rd2 <= mem2[addr2];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0][15:0] words;
        logic [15:0]      swaps;
        logic [15:0]      lat;
    } exp_t;

    exp_t sb[$];

    // Reference bubble sort with early exit; latency is cycles from the start edge to DONE.
    function automatic exp_t model8(input logic [7:0][15:0] w);
        exp_t        e;
        logic [15:0] t;
        bit          sw;
        int          cyc = 0;
        int          nsw = 0;
        for (int p = 0; p < 7; p++) begin
            sw = 1'b0;
            for (int i = 0; i < 7 - p; i++) begin
                cyc += 3;
                if (w[i] > w[i+1]) begin
                    t = w[i]; w[i] = w[i+1]; w[i+1] = t;
                    cyc += 2;
                    sw = 1'b1;
                    nsw++;
                end
            end
            if (!sw) break;
        end
        e.words = w;
        e.swaps = 16'(nsw);
        e.lat   = 16'(cyc + 1);
        return e;
    endfunction

    task automatic load8(input logic [7:0][15:0] w);
        for (int i = 0; i < 8; i++) init8[i] = w[i];
        do_load8 = 1'b1;
        @(negedge clk);
        do_load8 = 1'b0;
    endtask

    // Sort whatever mem8 currently holds; hold keeps start high through the DONE cycle.
    task automatic run8(input string name, input bit hold);
        logic [7:0][15:0] cur;
        exp_t e;
        int   cyc = 0;
        int   busy_low = 0;
        int   we0;
        bit   seen = 1'b0;
        for (int i = 0; i < 8; i++) cur[i] = mem8[i];
        sb.push_back(model8(cur));
        we0    = we_cnt8;
        start8 = 1'b1;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (!hold) start8 = 1'b0;
            if (done8) seen = 1'b1;
            else if (!busy8) busy_low++;
        end
        e = sb.pop_front();
        if (!seen) begin
            start8 = 1'b0;
            check({name, ".timeout"}, 32'd0, 32'd1);
            return;
        end
        check({name, ".latency"}, cyc, e.lat);
        check({name, ".busy_during"}, busy_low, 0);
        check({name, ".busy_at_done"}, busy8, 1);
        check({name, ".swap_count"}, sc8, e.swaps);
        check({name, ".writes"}, we_cnt8 - we0, 2 * e.swaps);
        if (hold) begin
            @(posedge clk);
            #1 start8 = 1'b0;
        end
        @(negedge clk);
        check({name, ".done_pulse"}, done8, 0);
        check({name, ".busy_after"}, busy8, 0);
        repeat (3) @(negedge clk);
        check({name, ".no_restart"}, busy8, 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s.word%0d", name, i), mem8[i], e.words[i]);
    endtask

    initial begin
        exp_t e2;
        int   cyc;
        int   guard;
        int   we0;
        bit   seen;

        rst = 1'b1; start8 = 1'b0; start2 = 1'b0; do_load8 = 1'b0; do_load2 = 1'b0;
        for (int i = 0; i < 8; i++) init8[i] = '0;
        for (int i = 0; i < 2; i++) init2[i] = '0;
        repeat (2) @(negedge clk);
        check("rst.busy", busy8, 0);
        check("rst.done", done8, 0);
        check("rst.we", we8, 0);
        check("rst.addr", addr8, 0);
        check("rst.wdata", wd8, 0);
        check("rst.swap_count", sc8, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle.busy", busy8, 0);
        check("idle.busy2", busy2, 0);

        load8({16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
        run8("sorted", 1'b0);

        load8({16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8});
        run8("reverse", 1'b0);

        load8({16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0001, 16'h8000, 16'h0001, 16'hFFFF});
        run8("dups", 1'b0);

        load8({16'd3, 16'd9, 16'd1, 16'd9, 16'd4, 16'd2, 16'd7, 16'd5});
        run8("handshake", 1'b1);

        // Reset while the second pair is in WR_A.
        load8({16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8});
        we0    = we_cnt8;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        guard  = 0;
        while (!(we8 && (we_cnt8 - we0) == 2) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("rst_mid.reached_wr_a", guard < 200, 1);
        check("rst_mid.swaps_before", sc8, 1);
        rst = 1'b1;
        #1;
        check("rst_mid.we", we8, 0);
        check("rst_mid.busy", busy8, 0);
        check("rst_mid.swap_count", sc8, 0);
        check("rst_mid.done", done8, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid.word0", mem8[0], 16'd7);
        check("rst_mid.word1", mem8[1], 16'd8);
        check("rst_mid.word2", mem8[2], 16'd6);
        run8("rerun", 1'b0);

        // N=2 build.
        init2[0] = 16'd5; init2[1] = 16'd3;
        do_load2 = 1'b1;
        @(negedge clk);
        do_load2 = 1'b0;
        e2.words = '0;
        e2.words[0] = 16'd3;
        e2.words[1] = 16'd5;
        e2.swaps = 16'd1;
        e2.lat   = 16'd6;
        sb.push_back(e2);
        start2 = 1'b1;
        cyc    = 0;
        seen   = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start2 = 1'b0;
            if (done2) seen = 1'b1;
        end
        e2 = sb.pop_front();
        check("n2.seen_done", seen, 1);
        check("n2.latency", cyc, e2.lat);
        check("n2.swap_count", sc2, e2.swaps);
        @(negedge clk);
        check("n2.busy_after", busy2, 0);
        check("n2.word0", mem2[0], e2.words[0]);
        check("n2.word1", mem2[1], e2.words[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bubble_sort_ctrl.md
# bubble_sort_ctrl

Sequencing stage of the bubble-sort engine: walks an external N-entry, 16-bit word memory in bubble-sort order, compares adjacent words, and writes them back swapped when out of order. It holds the two operand registers (A, B), the loop counters and the FSM. It drives the memory's address, write-data and write-enable lines. A start/busy/done handshake connects it to the top-level sequencer.

## Interface
- N, 8, number of words to sort; legal range 2..65535
- AW, $clog2(N), memory address width
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a sort; sampled only in IDLE
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the sort completes
- mem_addr  output  AW  word address for read or write
- mem_rd_data  input  16  read data; synchronous memory, valid one cycle after mem_addr
- mem_wr_data  output  16  write data
- mem_we  output  1  write strobe; the memory writes mem_wr_data at mem_addr on the edge
- swap_count  output  16  swaps performed in the current/last sort; saturates at 0xFFFF

## Operation
- States: IDLE, RD_A, RD_B, CMP, WR_A, WR_B, DONE.
- Counters:
  - pass runs 0..N-2.
  - i runs 0..N-2-pass.
  - swapped_flag records whether any swap occurred in the current pass.
- IDLE: when start=1, clear pass, i, swapped_flag and swap_count, then go to RD_A. Otherwise stay in IDLE.
- RD_A: mem_addr=i; go to RD_B.
- RD_B: mem_addr=i+1; latch mem_rd_data (word i) into reg_a; go to CMP.
- CMP:
  - Latch mem_rd_data (word i+1) into reg_b.
  - Compare reg_a against mem_rd_data, unsigned and strict.
  - If reg_a > word, go to WR_A.
  - Otherwise take the end-of-step decision.
- WR_A: mem_addr=i, mem_wr_data=reg_b, mem_we=1; go to WR_B.
- WR_B:
  - mem_addr=i+1, mem_wr_data=reg_a, mem_we=1.
  - Set swapped_flag and increment swap_count.
  - Then take the end-of-step decision.
- End-of-step decision:
  - If i < N-2-pass: i++ and go to RD_A.
  - Else, if swapped_flag=0 (counting a swap in this step) or pass=N-2: go to DONE.
  - Else: pass++, i=0, clear swapped_flag, go to RD_A.
- DONE: done=1, busy=1; go to IDLE.
- Equal words are never swapped, so the sort is stable.
- start is ignored while busy; a start arriving in the DONE cycle is ignored.
- In IDLE, RD_A, RD_B, CMP and DONE: mem_we=0 and mem_wr_data=0.
- In IDLE and DONE: mem_addr=0.

## Timing
- Reset values: state IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wr_data=0, swap_count=0; reg_a=reg_b=0 and all counters 0.
- rst mid-sort: return to IDLE immediately, asynchronously.
  - No further writes are issued.
  - Memory stays partially sorted.
  - done is not pulsed.
- mem_addr, mem_we and mem_wr_data are decoded from the registered state and counters. They are glitch-free relative to clk and have no combinational path from mem_rd_data.
- Per compared pair: 3 cycles without a swap, 5 cycles with a swap.
- Latency: first RD_A is the cycle after the start edge, and done is high in the cycle after the final CMP/WR_B.
- Already-sorted input, N=8: 1 pass, 21 cycles of RD_A/RD_B/CMP, then done.
- Worst case (reverse order): N(N-1)/2 swaps at 5 cycles each, plus 1 DONE cycle.
- busy falls the cycle after done.

## Structure
- Package bubble_sort_pkg holds:
  - word width constant W=16;
  - state enum sort_state_t;
  - swap_count saturation constant.
- Sub-module: reg_a and reg_b are each an instance of register16bit with enable tied high.
  - reg_a load=(state==RD_B); reg_b load=(state==CMP).
  - rst is shared.
- FSM, counters and output decode live in bubble_sort_ctrl itself.

## Test plan
- Sorted input, N=8, memory [1,2,3,4,5,6,7,8] -> no mem_we pulse; done 22 cycles after the start edge; swap_count=0; memory unchanged.
- Reverse input [8,7,6,5,4,3,2,1] -> final memory [1..8]; swap_count=28; done after 7 passes.
- Unsigned and duplicates, [0xFFFF,0x0001,0x8000,0x0001,0,0,0x7FFF,0x8000] -> final [0,0,1,1,0x7FFF,0x8000,0x8000,0xFFFF]; no writes issued for equal pairs.
- Handshake: start held high through a whole sort and pulsed during busy/DONE -> only one sort runs; busy=1 from the cycle after start until the cycle after done.
- Reset mid-sort: assert rst in a WR_A cycle -> same cycle mem_we=0, busy=0, swap_count=0; a new start then sorts correctly from the partially written memory.
- N=2 build, [5,3] -> one swap and 6 cycles to done; final [3,5]; swap_count=1.
